pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measuring end of the boost PWM path: samples a PWM waveform (gate-drive feedback or an external PWM source) and recovers its 10-bit duty value and its period.
- Uses the same tick base as the boost generator: one tick = PRESCALE system clocks (600 × 10 ns = 6 us).
- Sits beside boost in MG_mono. Supervisory logic compares duty_meas against d_boost and reads the stuck flags.

Parameters:
- PRESCALE, 600, system clocks per measurement tick.
- DW, 10, duty/counter width; nominal PWM period is 2^DW ticks.
- TIMEOUT, 2048, ticks without an edge before the stuck condition is declared (must be > 2^DW).
- FILT_N, 4, consecutive equal samples needed to accept a level (only with PWM_CAPTURE_FILTER_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous active-low reset.
- ce  in  1  capture enable; when low, the FSM holds in IDLE and counters clear.
- pwm_in  in  1  asynchronous PWM input.
- duty_meas  out  DW  high time of the last complete period, in ticks.
- period_meas  out  DW+1  total length of the last complete period, in ticks.
- meas_valid  out  1  one-clk strobe when duty_meas/period_meas update.
- stuck_hi  out  1  input held high ≥ TIMEOUT ticks.
- stuck_lo  out  1  input held low ≥ TIMEOUT ticks.

Behaviour:
- Reset (rst_n = 0 at a clk edge) clears: all outputs, the prescaler, both counters, the synchronizer; FSM → IDLE.
- Input path: 2-flop synchronizer on pwm_in. Edge detect compares the synchronized level with its registered copy. Edge-to-FSM latency = 3 clk.
- Prescaler: counts 0..PRESCALE-1 while ce = 1. tick = 1 for one clk at terminal count.
- Counters: hi_cnt (DW+1 bits) and lo_cnt (DW+1 bits) each increment on tick in their state and saturate at all-ones; no wrap.
- FSM states and transitions:
  - IDLE: wait for a rising edge → HIGH; clear hi_cnt/lo_cnt and the prescaler. Never measures a partial first period.
  - HIGH: count hi_cnt on tick. Falling edge → LOW.
  - LOW: count lo_cnt on tick. Rising edge → HIGH, and on that same clk:
    - latch duty_meas = min(hi_cnt, 2^DW−1);
    - latch period_meas = hi_cnt + lo_cnt, saturated at 2^(DW+1)−1;
    - pulse meas_valid; clear both counters.
  - meas_valid asserts 1 clk after the FSM sees the edge.
- Timeout: a separate idle-tick counter clears on any edge and increments on tick.
  - On reaching TIMEOUT: level high → stuck_hi = 1, duty_meas = 2^DW−1; level low → stuck_lo = 1, duty_meas = 0.
  - In both cases: period_meas = 0, one meas_valid pulse, FSM → IDLE.
  - Flags stay set until the next edge; they clear on the clk that edge is seen.
- Simultaneous events:
  - Edge and timeout on the same clk: the edge wins.
  - Edge and tick on the same clk: the tick counts into the old state's counter before the transition.
- ce deasserted mid-period: FSM → IDLE and counters clear; duty_meas/period_meas and the stuck flags hold their last values; no meas_valid.
- Reset mid-period: everything cleared per the reset rule; no strobe.

Optional Feature:
- PWM_CAPTURE_FILTER_EN defined:
  - A level filter sits after the synchronizer; its output changes only after FILT_N consecutive equal clk samples.
  - Pulses shorter than FILT_N clk are ignored.
  - Edge latency = 3 + FILT_N − 1 clk.
- Not defined: synchronizer output feeds the edge detector directly; a single-clk glitch is measured as a period.

Decomposition:
- Shared package mg_pkg holds:
  - the FSM state enum (IDLE, HIGH, LOW);
  - DW_DEFAULT = 10 and PRESCALE_DEFAULT = 600, shared with boost/pwm.
- One natural sub-module: pwm_edge_sync (synchronizer + optional filter + rise/fall strobes), reusable for the interrupt line.

Test Plan:
- PWM at 256/1024 duty, 1024-tick period (as boost produces for d_boost = 256) → after the second rising edge, meas_valid pulses; duty_meas = 256, period_meas = 1024; repeats every 1024 ticks.
- Duty sweep 0→1023 in steps of 128 → each update matches within ±1 tick. d = 0 (held low) → stuck_lo after 2048 ticks with duty_meas = 0.
- Hold pwm_in high for 3000 ticks → stuck_hi at tick 2048, duty_meas = 1023, period_meas = 0, one strobe. The next falling edge clears stuck_hi.
- rst_n low for 1 clk mid-HIGH → all outputs 0, FSM IDLE; no strobe until two rising edges later.
- ce low for 100 ticks mid-LOW → outputs held, no strobe; after ce returns, the first strobe follows the second rising edge.
- 3-clk glitch during LOW: with PWM_CAPTURE_FILTER_EN (FILT_N = 4) → ignored, result unchanged. Without the macro → extra meas_valid with a short period_meas.

Source files
------------

// File: rtl/mg_pkg.sv
// Shared definitions for the MG_mono PWM blocks (boost, pwm, pwm_capture).
package mg_pkg;

    localparam int DW_DEFAULT       = 10;
    localparam int PRESCALE_DEFAULT = 600;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_HIGH = 2'd1,
        CAP_LOW  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer with registered rise/fall strobes; PWM_CAPTURE_FILTER_EN
// adds a level filter that needs FILT_N equal samples before accepting a change.
module pwm_edge_sync
`ifdef PWM_CAPTURE_FILTER_EN
#(
    parameter int FILT_N = 4
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic lvl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int CW = $clog2(FILT_N) + 1;

    logic [CW-1:0] filt_cnt;

    // The FILT_N-th consecutive differing sample flips the level and fires the strobe together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q    <= 1'b0;
            filt_cnt <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == lvl_q) begin
                filt_cnt <= '0;
            end else if (filt_cnt == CW'(FILT_N - 1)) begin
                lvl_q    <= sync2;
                filt_cnt <= '0;
                rise     <= sync2;
                fall     <= ~sync2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            lvl_q <= sync2;
            rise  <= sync2 & ~lvl_q;
            fall  <= ~sync2 & lvl_q;
        end
    end
`endif

    assign level = lvl_q;

endmodule

// File: rtl/pwm_capture.sv
// Recovers duty (high ticks) and period of a PWM input on the boost tick base,
// flagging a stuck line; PWM_CAPTURE_FILTER_EN enables the input level filter.
module pwm_capture
    import mg_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int TIMEOUT  = 2048
`ifdef PWM_CAPTURE_FILTER_EN
    ,
    parameter int FILT_N   = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          pwm_in,
    output logic [DW-1:0] duty_meas,
    output logic [DW:0]   period_meas,
    output logic          meas_valid,
    output logic          stuck_hi,
    output logic          stuck_lo,
    output logic [1:0]    state_dbg
);

    // meas_valid is a bare one-clk strobe with no ready: consumers sample duty_meas,
    // period_meas and the stuck flags on that clk or later, as they hold until the next strobe.

    localparam int PW = $clog2(PRESCALE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0]    S_IDLE   = CAP_IDLE;
    localparam logic [1:0]    S_HIGH   = CAP_HIGH;
    localparam logic [1:0]    S_LOW    = CAP_LOW;
    localparam logic [DW:0]   CNT_MAX  = '1;
    localparam logic [DW-1:0] DUTY_MAX = '1;

    logic          level;
    logic          rise;
    logic          fall;
    logic          edge_any;
    logic [1:0]    state;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [DW:0]   hi_cnt;
    logic [DW:0]   lo_cnt;
    logic [DW:0]   hi_nxt;
    logic [DW:0]   lo_nxt;
    logic [DW+1:0] sum;
    logic [DW:0]   period_sat;
    logic [DW-1:0] duty_sat;
    logic [TW-1:0] idle_cnt;
    logic          timeout_hit;

`ifdef PWM_CAPTURE_FILTER_EN
    pwm_edge_sync #(.FILT_N(FILT_N)) u_sync (
`else
    pwm_edge_sync u_sync (
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign edge_any = rise | fall;
    assign tick     = ce && (pre_cnt == PW'(PRESCALE - 1));

    // Next counter values include this clk's tick so a tick coinciding with an edge lands in the old state.
    always_comb begin
        hi_nxt = hi_cnt;
        lo_nxt = lo_cnt;
        if (tick && state == S_HIGH && hi_cnt != CNT_MAX) hi_nxt = hi_cnt + 1'b1;
        if (tick && state == S_LOW  && lo_cnt != CNT_MAX) lo_nxt = lo_cnt + 1'b1;
    end

    assign sum         = {1'b0, hi_nxt} + {1'b0, lo_nxt};
    assign period_sat  = sum[DW+1] ? CNT_MAX : sum[DW:0];
    assign duty_sat    = hi_nxt[DW] ? DUTY_MAX : hi_nxt[DW-1:0];
    assign timeout_hit = tick && !edge_any && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            idle_cnt    <= '0;
            duty_meas   <= '0;
            period_meas <= '0;
            meas_valid  <= 1'b0;
            stuck_hi    <= 1'b0;
            stuck_lo    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!ce) begin
                state    <= S_IDLE;
                pre_cnt  <= '0;
                hi_cnt   <= '0;
                lo_cnt   <= '0;
                idle_cnt <= '0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                hi_cnt  <= hi_nxt;
                lo_cnt  <= lo_nxt;

                if (edge_any) begin
                    idle_cnt <= '0;
                    stuck_hi <= 1'b0;
                    stuck_lo <= 1'b0;
                end else if (tick && idle_cnt != TW'(TIMEOUT)) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end

                case (state)
                    S_IDLE: begin
                        if (rise) begin
                            state   <= S_HIGH;
                            pre_cnt <= '0;
                            hi_cnt  <= '0;
                            lo_cnt  <= '0;
                        end
                    end
                    S_HIGH: begin
                        if (fall) state <= S_LOW;
                    end
                    S_LOW: begin
                        if (rise) begin
                            state       <= S_HIGH;
                            duty_meas   <= duty_sat;
                            period_meas <= period_sat;
                            meas_valid  <= 1'b1;
                            hi_cnt      <= '0;
                            lo_cnt      <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                // timeout_hit excludes edges, so it never competes with a transition above.
                if (timeout_hit) begin
                    state       <= S_IDLE;
                    stuck_hi    <= level;
                    stuck_lo    <= ~level;
                    duty_meas   <= level ? DUTY_MAX : '0;
                    period_meas <= '0;
                    meas_valid  <= 1'b1;
                    hi_cnt      <= '0;
                    lo_cnt      <= '0;
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a short prescaler so full 1024-tick periods
// stay cheap; every strobe is captured and compared against hand-computed values.
module tb_pwm_capture;
    import mg_pkg::*;

    localparam int P  = 2;
    localparam int DW = 10;
    localparam int TO = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          pwm_in;
    logic [DW-1:0] duty_meas;
    logic [DW:0]   period_meas;
    logic          meas_valid;
    logic          stuck_hi;
    logic          stuck_lo;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    logic [20:0] obs_q[$];

    always #5 clk = ~clk;

    pwm_capture #(.PRESCALE(P), .DW(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .pwm_in      (pwm_in),
        .duty_meas   (duty_meas),
        .period_meas (period_meas),
        .meas_valid  (meas_valid),
        .stuck_hi    (stuck_hi),
        .stuck_lo    (stuck_lo),
        .state_dbg   (state_dbg)
    );

    // Strobe monitor: every meas_valid pulse records the values it qualifies.
    always @(negedge clk) begin
        if (meas_valid) obs_q.push_back({duty_meas, period_meas});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_meas(input string tag, input int d, input int p);
        logic [20:0] m;
        checks++;
        assert (obs_q.size() > 0) else begin
            errors++;
            $error("FAIL %s: observed no strobe expected duty %0d period %0d", tag, d, p);
        end
        if (obs_q.size() > 0) begin
            m = obs_q.pop_front();
            check_eq({tag, "_duty"}, 32'(m[20:11]), d);
            check_eq({tag, "_period"}, 32'(m[10:0]), p);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n * P) @(negedge clk);
    endtask

    task automatic drive(input logic lvl, input int n);
        pwm_in = lvl;
        ticks(n);
    endtask

    int hi_t[9]  = '{256, 256, 256, 128, 384, 640, 896, 1020, 1030};
    int lo_t[9]  = '{768, 768, 768, 896, 640, 384, 128,    4,   10};
    int exp_d[9] = '{256, 256, 256, 128, 384, 640, 896, 1020, 1023};
    int exp_p[9] = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1040};

    initial begin
        logic [20:0] m;

        // reset state
        rst_n  = 1'b0;
        ce     = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_duty", 32'(duty_meas), 0);
        check_eq("rst_period", 32'(period_meas), 0);
        check_eq("rst_valid", 32'(meas_valid), 0);
        check_eq("rst_stuck_hi", 32'(stuck_hi), 0);
        check_eq("rst_stuck_lo", 32'(stuck_lo), 0);
        check_eq("rst_state", 32'(state_dbg), 32'(CAP_IDLE));
        rst_n = 1'b1;
        ce    = 1'b1;

        // nominal 256/1024, duty sweep and the saturated-duty case
        drive(1'b0, 10);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, hi_t[i]);
            drive(1'b0, lo_t[i]);
        end
        pwm_in = 1'b1;
        ticks(4);
        check_eq("sweep_count", obs_q.size(), 9);
        for (int i = 0; i < 9; i++) check_meas($sformatf("meas%0d", i), exp_d[i], exp_p[i]);

        // held high past the timeout
        ticks(2036);
        check_eq("stuck_hi_early", 32'(stuck_hi), 0);
        check_eq("stuck_hi_early_strobe", obs_q.size(), 0);
        ticks(960);
        check_eq("stuck_hi_set", 32'(stuck_hi), 1);
        check_eq("stuck_hi_lo_flag", 32'(stuck_lo), 0);
        check_eq("stuck_hi_state", 32'(state_dbg), 32'(CAP_IDLE));
        check_meas("stuck_hi", 1023, 0);
        check_eq("stuck_hi_single", obs_q.size(), 0);
        drive(1'b0, 4);
        check_eq("stuck_hi_cleared", 32'(stuck_hi), 0);
        check_eq("fall_in_idle_no_strobe", obs_q.size(), 0);

        // held low past the timeout
        ticks(2096);
        check_eq("stuck_lo_set", 32'(stuck_lo), 1);
        check_meas("stuck_lo", 0, 0);
        drive(1'b1, 4);
        check_eq("stuck_lo_cleared", 32'(stuck_lo), 0);
        check_eq("stuck_lo_rise_state", 32'(state_dbg), 32'(CAP_HIGH));
        ticks(96);

        // one-clk reset mid-HIGH
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_duty", 32'(duty_meas), 0);
        check_eq("midrst_period", 32'(period_meas), 0);
        check_eq("midrst_valid", 32'(meas_valid), 0);
        check_eq("midrst_stuck", 32'({stuck_hi, stuck_lo}), 0);
        check_eq("midrst_state", 32'(state_dbg), 32'(CAP_IDLE));
        drive(1'b0, 50);
        drive(1'b1, 300);
        check_eq("midrst_first_rise_no_strobe", obs_q.size(), 0);
        check_eq("midrst_first_rise_state", 32'(state_dbg), 32'(CAP_HIGH));
        drive(1'b0, 724);
        pwm_in = 1'b1;
        ticks(4);
        check_meas("after_rst", 300, 1024);
        check_eq("after_rst_single", obs_q.size(), 0);

        // ce low mid-LOW
        ticks(196);
        drive(1'b0, 100);
        ce = 1'b0;
        ticks(100);
        check_eq("ce_off_state", 32'(state_dbg), 32'(CAP_IDLE));
        check_eq("ce_off_duty_held", 32'(duty_meas), 300);
        check_eq("ce_off_period_held", 32'(period_meas), 1024);
        check_eq("ce_off_no_strobe", obs_q.size(), 0);
        ce = 1'b1;
        drive(1'b0, 50);
        drive(1'b1, 200);
        drive(1'b0, 824);
        pwm_in = 1'b1;
        ticks(4);
        check_meas("after_ce", 200, 1024);
        check_eq("after_ce_single", obs_q.size(), 0);

        // 3-clk glitch during LOW
        ticks(196);
        drive(1'b0, 300);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        pwm_in = 1'b0;
        repeat (524 * P - 3) @(negedge clk);
        pwm_in = 1'b1;
        ticks(4);
`ifdef PWM_CAPTURE_FILTER_EN
        check_eq("glitch_filtered_count", obs_q.size(), 1);
        check_meas("glitch_filtered", 200, 1024);
`else
        check_eq("glitch_count", obs_q.size(), 2);
        check_meas("glitch_first", 200, 500);
        checks++;
        assert (obs_q.size() > 0) else begin
            errors++;
            $error("FAIL glitch_second: observed no strobe expected period 524");
        end
        if (obs_q.size() > 0) begin
            m = obs_q.pop_front();
            check_eq("glitch_second_period", 32'(m[10:0]), 524);
            check_eq("glitch_second_duty_1_or_2", 32'(m[20:11] == 10'd1 || m[20:11] == 10'd2), 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
